alu_seq_core: RTL

Parametrised successor to the button-driven ALU top: a single block that debounces the push-button and sequences through an opcode list. Each accepted press executes the current opcode on registered operands and returns a registered result with status flags and a one-cycle valid strobe. It replaces the separate controller/datapath pair at board top level and is generic in operand width and debounce length.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 72 +++++++
 rtl/alu_seq_core.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, flag bit positions and FSM state type for alu_seq_core.
// Defining ALU_MUL_EN adds the MUL opcode and extends the opcode sequence to nine entries.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

`ifdef ALU_MUL_EN
    localparam logic [3:0] NUM_OPS = 4'd9;
`else
    localparam logic [3:0] NUM_OPS = 4'd8;
`endif

    // Bit positions inside flags = {negative, overflow, carry, zero}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debounce filter and
// rising-edge detect producing a single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    logic       sync_1;
    logic       sync_2;
    logic [1:0] fill;
    logic       level;
    logic       level_d;
    logic       armed;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            fill   <= 2'b00;
        end else begin
            sync_1 <= button;
            sync_2 <= sync_1;
            fill   <= {fill[0], 1'b1};
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nofilter
            assign level = sync_2;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (sync_2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

    // A press is honoured only once a real low level has passed through the
    // synchroniser, so a button held across reset release must be let go first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            level_d <= level;
            if (fill[1] && !sync_2) begin
                armed <= 1'b1;
            end
        end
    end

    assign press = armed && level && !level_d;

endmodule

// File: rtl/alu_seq_core.sv
// Button-sequenced ALU: each debounced press executes the current opcode on latched operands.
// Optional feature macro ALU_MUL_EN adds opcode 8 (MUL) and a WIDTH x WIDTH multiplier.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button,
    input  logic [WIDTH-1:0] number_1,
    input  logic [WIDTH-1:0] number_2,
    output logic [WIDTH-1:0] answer,
    output logic [3:0]       opcode,
    output logic [3:0]       flags,
    output logic             valid
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             press;
    logic             latch_en;
    logic             exec_en;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_sel;
    logic [WIDTH-1:0] result;
    logic [3:0]       result_flags;
    logic             carry;
    logic             ovf;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .press  (press)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Presses arriving during EXEC are dropped rather than queued.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (press) state_next = S_EXEC;
            S_EXEC:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        latch_en = (state == S_IDLE) && press;
        exec_en  = (state == S_EXEC);
    end

    // Bit WIDTH of the difference is the unsigned borrow.
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] product;
    assign product = op_a * op_b;
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op_sel)
            OP_ADD: begin
                result = sum_ext[WIDTH-1:0];
                carry  = sum_ext[WIDTH];
                ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff_ext[WIDTH-1:0];
                carry  = diff_ext[WIDTH];
                ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: result = op_a & op_b;
            OP_OR:  result = op_a | op_b;
            OP_XOR: result = op_a ^ op_b;
            OP_NOT: result = ~op_a;
            OP_SHL: result = op_a << op_b[SHW-1:0];
            OP_SHR: result = op_a >> op_b[SHW-1:0];
`ifdef ALU_MUL_EN
            OP_MUL: begin
                result = product[WIDTH-1:0];
                carry  = |product[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
        result_flags         = '0;
        result_flags[FLAG_Z] = (result == '0);
        result_flags[FLAG_C] = carry;
        result_flags[FLAG_V] = ovf;
        result_flags[FLAG_N] = result[WIDTH-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= OP_ADD;
            opcode <= OP_ADD;
            answer <= '0;
            flags  <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= exec_en;
            if (latch_en) begin
                op_a   <= number_1;
                op_b   <= number_2;
                op_sel <= opcode;
                opcode <= (opcode == NUM_OPS - 4'd1) ? OP_ADD : opcode + 4'd1;
            end
            if (exec_en) begin
                answer <= result;
                flags  <= result_flags;
            end
        end
    end

endmodule
